// File: rtl/aes_block_loader.sv
// Loads a 128-bit key and state from a 32-bit valid/ready word stream and holds them for the AES core.
// Latency: core_start the cycle after the last state word; done CORE_LAT cycles after core_start.
// Backpressure: in_ready low while the core holds its inputs, during abort, and on a key-reuse skip cycle.
module aes_block_loader #(
    parameter int CORE_LAT = 10,
    parameter int CNT_W    = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         keep_key,
    input  logic         abort,
    output logic [127:0] state,
    output logic [127:0] key,
    output logic         core_start,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {S_KEY, S_STATE, S_HOLD, S_DONE} fsm_e;

    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(CORE_LAT - 1);

    fsm_e             fsm_q, fsm_d;
    logic [1:0]       word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0] lat_cnt_q, lat_cnt_d;
    logic             key_vld_q, key_vld_d;
    logic [127:0]     state_q, state_d;
    logic [127:0]     key_q, key_d;
    logic             core_start_q, core_start_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             skip_key;
    logic             xfer;

    always_comb begin
        skip_key = (fsm_q == S_KEY) && keep_key && key_vld_q && (word_cnt_q == 2'd0);
        // rst gates in_ready so nothing is offered as accepted while reset is held
        in_ready = rst && !abort && !skip_key && ((fsm_q == S_KEY) || (fsm_q == S_STATE));
        xfer     = in_valid && in_ready;

        fsm_d        = fsm_q;
        word_cnt_d   = word_cnt_q;
        lat_cnt_d    = lat_cnt_q;
        key_vld_d    = key_vld_q;
        state_d      = state_q;
        key_d        = key_q;
        core_start_d = 1'b0;
        done_d       = 1'b0;

        if (abort) begin
            fsm_d      = S_KEY;
            word_cnt_d = 2'd0;
            lat_cnt_d  = '0;
            if ((fsm_q == S_KEY) && (word_cnt_q != 2'd0)) begin
                key_vld_d = 1'b0;
            end
        end else begin
            case (fsm_q)
                S_KEY: begin
                    if (skip_key) begin
                        fsm_d = S_STATE;
                    end else if (xfer) begin
                        // word 0 lands in the top 32 bits
                        key_d[{~word_cnt_q, 5'd0} +: 32] = in_data;
                        word_cnt_d = word_cnt_q + 2'd1;
                        if (word_cnt_q == 2'd3) begin
                            key_vld_d = 1'b1;
                            fsm_d     = S_STATE;
                        end
                    end
                end
                S_STATE: begin
                    if (xfer) begin
                        state_d[{~word_cnt_q, 5'd0} +: 32] = in_data;
                        word_cnt_d = word_cnt_q + 2'd1;
                        if (word_cnt_q == 2'd3) begin
                            fsm_d        = S_HOLD;
                            lat_cnt_d    = '0;
                            core_start_d = 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    lat_cnt_d = lat_cnt_q + CNT_W'(1);
                    if (lat_cnt_q == LAT_LAST) begin
                        fsm_d     = S_DONE;
                        lat_cnt_d = '0;
                        done_d    = 1'b1;
                    end
                end
                default: begin
                    fsm_d      = S_KEY;
                    word_cnt_d = 2'd0;
                    lat_cnt_d  = '0;
                end
            endcase
        end

        busy_d = (fsm_d == S_HOLD) || (fsm_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q        <= S_KEY;
            word_cnt_q   <= 2'd0;
            lat_cnt_q    <= '0;
            key_vld_q    <= 1'b0;
            state_q      <= '0;
            key_q        <= '0;
            core_start_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            fsm_q        <= fsm_d;
            word_cnt_q   <= word_cnt_d;
            lat_cnt_q    <= lat_cnt_d;
            key_vld_q    <= key_vld_d;
            state_q      <= state_d;
            key_q        <= key_d;
            core_start_q <= core_start_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign state      = state_q;
    assign key        = key_q;
    assign core_start = core_start_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_aes_block_loader.sv
// Bench for aes_block_loader: directed vector table, abort/reset sequences, random blocks vs a block-level model.
module tb_aes_block_loader;

    localparam int L = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         keep_key;
    logic         abort;
    logic [127:0] state;
    logic [127:0] key;
    logic         core_start;
    logic         busy;
    logic         done;

    aes_block_loader #(.CORE_LAT(L), .CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .keep_key   (keep_key),
        .abort      (abort),
        .state      (state),
        .key        (key),
        .core_start (core_start),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // block-level model: last fully loaded key and whether it may be reused
    logic [127:0] m_key;
    bit           m_kvld;
    logic [31:0]  wq[$];

    typedef struct {
        bit           kk;
        logic [127:0] kin;
        logic [127:0] sin;
        int           mode;
        logic [127:0] exp_key;
        int           exp_words;
        int           exp_span;
    } vec_t;

    vec_t tbl[4];

    localparam logic [127:0] FIPS_K = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_S = 128'h3243f6a8885a308d313198a2e0370734;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push128(input logic [127:0] v);
        for (int i = 3; i >= 0; i--) wq.push_back(v[32*i +: 32]);
    endtask

    // mode 0: continuous valid, 1: toggle every cycle, 2: random gaps
    task automatic feed(input int mode, output int first_c);
        int  guard;
        bit  tog;
        guard   = 0;
        tog     = 1'b1;
        first_c = -1;
        while (wq.size() > 0 && guard < 500) begin
            case (mode)
                0:       in_valid = 1'b1;
                1:       begin in_valid = tog; tog = !tog; end
                default: in_valid = ($urandom_range(0, 3) != 0);
            endcase
            in_data = wq[0];
            @(negedge clk);
            chk("load_flags", {core_start, busy, done}, 3'b000);
            if (in_valid && in_ready) begin
                if (first_c < 0) first_c = cyc;
                void'(wq.pop_front());
            end
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b0;
        chk("feed_timeout", 128'(wq.size()), 0);
        wq.delete();
    endtask

    task automatic check_hold(input logic [127:0] ek, input logic [127:0] es,
                              input int first_c, input int exp_span);
        int cs_c;
        @(negedge clk);
        chk("core_start", {core_start, done, in_ready, busy}, 4'b1001);
        chk("key_out", key, ek);
        chk("state_out", state, es);
        cs_c = cyc;
        for (int i = 1; i < L; i++) begin
            @(negedge clk);
            chk("hold_flags", {core_start, done, in_ready, busy}, 4'b0001);
            chk("hold_key", key, ek);
            chk("hold_state", state, es);
        end
        @(negedge clk);
        chk("done_pulse", {core_start, done, in_ready, busy}, 4'b0101);
        chk("done_after_start", 128'(cyc - cs_c), L);
        if (exp_span >= 0) chk("done_latency", 128'(cyc - first_c), 128'(exp_span));
        @(negedge clk);
        chk("after_done", {core_start, done, in_ready, busy}, 4'b0010);
        @(posedge clk); #1;
    endtask

    task automatic run_block(input bit kk, input logic [127:0] kin, input logic [127:0] sin,
                             input int mode, input logic [127:0] exp_key,
                             input int exp_words, input int exp_span);
        int f;
        wq.delete();
        if (exp_words == 8) push128(kin);
        push128(sin);
        keep_key = kk;
        feed(mode, f);
        keep_key = 1'b0;
        check_hold(exp_key, sin, f, exp_span);
        m_key  = exp_key;
        m_kvld = 1'b1;
    endtask

    task automatic pulse_abort();
        in_valid = 1'b1;
        in_data  = 32'hdeadbeef;
        abort    = 1'b1;
        @(negedge clk);
        chk("abort_blocks_ready", in_ready, 0);
        @(posedge clk); #1;
        abort    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] ka, sa, kb, sb;
        bit           kk, use_key;

        tbl[0] = '{1'b1, FIPS_K, FIPS_S, 0, FIPS_K, 8, 18};
        tbl[1] = '{1'b1, {4{32'hffffffff}}, 128'h00001111222233334444555566667777, 0, FIPS_K, 4, 14};
        tbl[2] = '{1'b0, 128'h000102030405060708090a0b0c0d0e0f,
                   128'h00112233445566778899aabbccddeeff, 1,
                   128'h000102030405060708090a0b0c0d0e0f, 8, -1};
        tbl[3] = '{1'b1, {4{32'h55555555}}, 128'hfedcba9876543210f0e1d2c3b4a59687, 1,
                   128'h000102030405060708090a0b0c0d0e0f, 4, -1};

        rst      = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'h12345678;
        keep_key = 1'b0;
        abort    = 1'b0;
        m_key    = '0;
        m_kvld   = 1'b0;
        #2;
        chk("reset_flags", {core_start, busy, done, in_ready}, 4'b0000);
        chk("reset_key", key, 0);
        chk("reset_state", state, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst      = 1'b1;

        for (int i = 0; i < 4; i++)
            run_block(tbl[i].kk, tbl[i].kin, tbl[i].sin, tbl[i].mode,
                      tbl[i].exp_key, tbl[i].exp_words, tbl[i].exp_span);

        // abort after two state words: partial state stays, key remains reusable but not consumed
        ka = 128'ha0a1a2a3b0b1b2b3c0c1c2c3d0d1d2d3;
        sa = 128'h11111111222222223333333344444444;
        wq.delete();
        push128(ka);
        wq.push_back(sa[127:96]);
        wq.push_back(sa[95:64]);
        begin int f; feed(0, f); end
        pulse_abort();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_idle", {core_start, busy, done, in_ready}, 4'b0001);
        end
        chk("abort_partial_state", state[127:64], sa[127:64]);
        chk("abort_key_kept", key, ka);
        @(posedge clk); #1;
        kb = 128'h0f0e0d0c0b0a09080706050403020100;
        sb = 128'h99998888777766665555444433332222;
        run_block(1'b0, kb, sb, 0, kb, 8, 18);

        // abort mid-key: key_vld cleared, so keep_key must be ignored afterwards
        wq.delete();
        wq.push_back(32'hc0ffee01);
        wq.push_back(32'hc0ffee02);
        begin int f; feed(0, f); end
        pulse_abort();
        @(negedge clk);
        chk("midkey_partial", key[127:64], 64'hc0ffee01c0ffee02);
        @(posedge clk); #1;
        run_block(1'b1, ka, sa, 0, ka, 8, 18);

        // abort during hold: no done for that block
        wq.delete();
        push128(kb);
        push128(sb);
        begin int f; feed(0, f); end
        @(negedge clk);
        chk("hold_abort_start", core_start, 1);
        @(posedge clk); #1;
        abort = 1'b1;
        @(negedge clk);
        chk("hold_abort_ready", in_ready, 0);
        @(posedge clk); #1;
        abort = 1'b0;
        for (int i = 0; i < L + 2; i++) begin
            @(negedge clk);
            chk("hold_abort_quiet", {core_start, busy, done}, 3'b000);
        end
        @(posedge clk); #1;
        m_key  = kb;
        m_kvld = 1'b1;

        // async reset in the middle of hold
        wq.delete();
        push128(ka);
        push128(sb);
        begin int f; feed(0, f); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_flags", {core_start, busy, done, in_ready}, 4'b0000);
        chk("rst_key", key, 0);
        chk("rst_state", state, 0);
        @(posedge clk); #1;
        rst    = 1'b1;
        m_kvld = 1'b0;
        run_block(1'b1, FIPS_K, FIPS_S, 0, FIPS_K, 8, 18);

        // random blocks against the model
        for (int n = 0; n < 25; n++) begin
            kk      = ($urandom_range(0, 1) == 1);
            ka      = {$urandom, $urandom, $urandom, $urandom};
            sa      = {$urandom, $urandom, $urandom, $urandom};
            use_key = !(kk && m_kvld);
            run_block(kk, ka, sa, 2, use_key ? ka : m_key, use_key ? 8 : 4, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
